// File: rtl/arb8_priority_ctrl.sv
// 8-requester arbiter with fixed-priority or round-robin selection, a per-grant
// hold limit and a mandatory idle bubble between consecutive grants.
module arb8_priority_ctrl #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rr_mode,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       hold_expired
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       grant_q, grant_d;
  logic [2:0]       id_q, id_d;
  logic [2:0]       last_q, last_d;
  logic             valid_q, valid_d;
  logic             exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Both modes share one encoder: rotating by last_id makes rot[7] the
  // requester at last_id-1, so the highest set bit of rot is the RR winner.
  // Fixed priority is the same search with a rotation of zero.
  logic [2:0] base;
  logic [7:0] rot;
  logic [2:0] sel_j;
  logic [2:0] winner;

  assign base = rr_mode ? last_q : 3'd0;

  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    localparam logic [2:0] OFF = 3'(gi);
    logic [2:0] src;
    assign src     = base + OFF;
    assign rot[gi] = req[src];
  end

  always_comb begin
    sel_j = 3'd0;
    for (int j = 0; j < 8; j++) begin
      if (rot[j]) sel_j = 3'(j);
    end
  end

  assign winner = base + sel_j;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    valid_d = valid_q;
    exp_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        grant_d = 8'h00;
        valid_d = 1'b0;
        if (|req) begin
          state_d = GRANT;
          grant_d = 8'b1 << winner;
          id_d    = winner;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!req[id_q]) begin
          state_d = IDLE;
          grant_d = 8'h00;
          valid_d = 1'b0;
          last_d  = id_q;
        end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
          state_d = IDLE;
          grant_d = 8'h00;
          valid_d = 1'b0;
          exp_d   = 1'b1;
          last_d  = id_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 8'h00;
      id_q    <= 3'd0;
      last_q  <= 3'd0;
      valid_q <= 1'b0;
      exp_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant        = grant_q;
  assign grant_id     = id_q;
  assign grant_valid  = valid_q;
  assign hold_expired = exp_q;

endmodule

// File: tb/tb_arb8_priority_ctrl.sv
// Self-checking bench: three arbiters (MAX_HOLD 4, 2, 1) share stimulus and are
// compared every cycle against a behavioural arbitration model.
module tb_arb8_priority_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       rr_mode;

  logic [7:0] grant [3];
  logic [2:0] gid   [3];
  logic       gv    [3];
  logic       hx    [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    arb8_priority_ctrl #(
      .MAX_HOLD(gi == 0 ? 4 : (gi == 1 ? 2 : 1)),
      .CNT_W   (8)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .rr_mode     (rr_mode),
      .grant       (grant[gi]),
      .grant_id    (gid[gi]),
      .grant_valid (gv[gi]),
      .hold_expired(hx[gi])
    );
  end

  // Behavioural model: who owns the resource, for how long, and who went last.
  int mh       [3] = '{4, 2, 1};
  int m_busy   [3];
  int m_owner  [3];
  int m_held   [3];
  int m_last   [3];
  int m_gid    [3];
  int m_expired[3];

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_busy[d] = 0; m_owner[d] = 0; m_held[d] = 0;
      m_last[d] = 0; m_gid[d] = 0; m_expired[d] = 0;
    end
  endtask

  function automatic int pick(int d);
    int w;
    int found;
    int i;
    w = 0;
    found = 0;
    if (!rr_mode) begin
      for (int k = 7; k >= 0; k--)
        if (!found && req[k]) begin w = k; found = 1; end
    end else begin
      for (int k = 1; k <= 8; k++) begin
        i = (m_last[d] - k + 16) % 8;
        if (!found && req[i]) begin w = i; found = 1; end
      end
    end
    return w;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      m_expired[d] = 0;
      if (m_busy[d] == 0) begin
        if (req != 8'h00) begin
          m_owner[d] = pick(d);
          m_gid[d]   = m_owner[d];
          m_busy[d]  = 1;
          m_held[d]  = 1;
        end
      end else if (!req[m_owner[d]]) begin
        m_busy[d] = 0;
        m_last[d] = m_owner[d];
      end else if (m_held[d] == mh[d]) begin
        m_busy[d]    = 0;
        m_last[d]    = m_owner[d];
        m_expired[d] = 1;
      end else begin
        m_held[d]++;
      end
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] eg;
    for (int d = 0; d < 3; d++) begin
      eg = (m_busy[d] != 0) ? (8'h01 << m_owner[d]) : 8'h00;
      chk("grant", d, grant[d], eg);
      chk("grant_id", d, gid[d], m_gid[d]);
      chk("grant_valid", d, gv[d], m_busy[d]);
      chk("hold_expired", d, hx[d], m_expired[d]);
      chk("inv_onehot0", d, $onehot0(grant[d]), 1);
      chk("inv_valid_eq_or", d, gv[d], |grant[d]);
      chk("inv_exp_vs_valid", d, hx[d] & gv[d], 0);
    end
  endtask

  task automatic step(input logic [7:0] r, input logic m);
    req = r;
    rr_mode = m;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asynchronous reset applied between edges; outputs must clear before any edge.
  task automatic do_reset();
    req = 8'h00;
    rst_n = 1'b0;
    #2;
    for (int d = 0; d < 3; d++) begin
      chk("rst_grant", d, grant[d], 0);
      chk("rst_id", d, gid[d], 0);
      chk("rst_valid", d, gv[d], 0);
      chk("rst_expired", d, hx[d], 0);
    end
    model_reset();
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int         exp_cnt;
  int         rr_q[$];
  int         exp_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
  logic       prev_gv;
  logic [7:0] rnd;
  logic       rmode;

  initial begin
    rst_n = 1'b0;
    req = 8'h00;
    rr_mode = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Idle with no requests.
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0);

    // Fixed priority: req5 wins, drops, bubble, then req2.
    step(8'h26, 1'b0);
    chk("fixed_first_grant", 0, grant[0], 8'h20);
    step(8'h26, 1'b0);
    step(8'h26, 1'b0);
    step(8'h06, 1'b0);
    chk("fixed_release_bubble", 0, grant[0], 8'h00);
    step(8'h06, 1'b0);
    chk("fixed_second_id", 0, gid[0], 3'd2);

    // Fixed priority, persistent req7: expiry every 5 cycles on the MAX_HOLD=4 unit.
    do_reset();
    exp_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step(8'h80, 1'b0);
      if (hx[0]) exp_cnt++;
    end
    chk("fixed_expiry_count", 0, exp_cnt, 3);

    // Round-robin, all requesting, MAX_HOLD=2 unit rotates 7..0 then 7.
    do_reset();
    prev_gv = 1'b0;
    for (int i = 0; i < 27; i++) begin
      step(8'hFF, 1'b1);
      if (gv[1] && !prev_gv) rr_q.push_back(int'(gid[1]));
      prev_gv = gv[1];
    end
    chk("rr_seq_len", 1, rr_q.size(), 9);
    for (int i = 0; i < 9; i++)
      chk("rr_seq_id", 1, (i < rr_q.size()) ? rr_q[i] : 32'hFFFF, exp_seq[i]);

    // Round-robin, no preemption, then search continues below the old owner.
    do_reset();
    step(8'h08, 1'b1);
    chk("rr_owner3", 0, gid[0], 3'd3);
    step(8'h8A, 1'b1);
    step(8'h8A, 1'b1);
    chk("rr_no_preempt", 0, grant[0], 8'h08);
    step(8'h82, 1'b1);
    step(8'h82, 1'b1);
    chk("rr_next_id1", 0, gid[0], 3'd1);
    step(8'h80, 1'b1);
    step(8'h80, 1'b1);
    chk("rr_then_id7", 0, gid[0], 3'd7);

    // Reset mid-grant, then a fresh grant with a restarted hold count.
    do_reset();
    step(8'h08, 1'b0);
    step(8'h08, 1'b0);
    step(8'h08, 1'b0);
    do_reset();
    step(8'h01, 1'b0);
    chk("post_reset_grant", 0, grant[0], 8'h01);
    for (int i = 0; i < 6; i++) step(8'h01, 1'b0);

    // Randomised traffic with occasional mode switches and resets.
    do_reset();
    rmode = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) do_reset();
      if ($urandom_range(0, 15) == 0) rmode = ~rmode;
      case ($urandom_range(0, 3))
        0: rnd = 8'($urandom);
        1: rnd = 8'($urandom) & 8'($urandom);
        2: rnd = 8'h01 << $urandom_range(0, 7);
        default: rnd = (i % 7 == 0) ? 8'h00 : req;
      endcase
      step(rnd, rmode);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
